// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed evaluator for one LUT-neuron layer: one shared truth-table RAM
// is read once per neuron, and the results are assembled into out_data.
module lut_layer_sequencer #(
    parameter int NEURONS = 4,
    parameter int FANIN   = 4,
    parameter int IN_BW   = 2,
    parameter int OUT_BW  = 2,
    parameter int IN_CH   = 16,
    localparam int NW     = $clog2(NEURONS),
    localparam int LW     = FANIN * IN_BW,
    localparam int CW     = $clog2(IN_CH),
    localparam int WDW    = (OUT_BW > CW) ? OUT_BW : CW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_CH*IN_BW-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NEURONS*OUT_BW-1:0] out_data,
    input  logic                      cfg_we,
    input  logic                      cfg_sel,
    input  logic [NW+LW-1:0]          cfg_addr,
    input  logic [WDW-1:0]            cfg_wdata,
    output logic                      cfg_ready,
    output logic                      cfg_err
);
    localparam int FW = $clog2(FANIN);
    localparam int AW = NW + FW;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits for ready, and the payload is held stable while valid && !ready.
    typedef enum logic [1:0] {IDLE, EVAL, DRAIN, HOLD} state_t;
    state_t state, state_next;

    logic [IN_CH*IN_BW-1:0] vec;
    logic [NW-1:0]          k;
    logic [CW-1:0]          conn [NEURONS*FANIN];
    logic [OUT_BW-1:0]      ram [NEURONS*(2**LW)];
    logic [OUT_BW-1:0]      rd_data;
    logic [NW-1:0]          rd_k;
    logic                   rd_valid;
    logic [LW-1:0]          lut_index;
    logic [NW+LW-1:0]       rd_addr;
    logic                   accept, issue, conn_bad, cfg_take;

    assign in_ready  = (state == IDLE);
    assign cfg_ready = (state == IDLE);
    assign out_valid = (state == HOLD);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = EVAL;
                end
            end
            EVAL: begin
                issue = 1'b1;
                if (k == NW'(NEURONS - 1)) state_next = DRAIN;
            end
            DRAIN: state_next = HOLD;
            HOLD: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Slot j of neuron k supplies lut_index bits [j*IN_BW +: IN_BW]; slot 0 is the LSBs.
    always_comb begin
        lut_index = '0;
        for (int j = 0; j < FANIN; j++) begin
            lut_index[j*IN_BW +: IN_BW] = vec[int'(conn[{k, FW'(j)}]) * IN_BW +: IN_BW];
        end
    end
    assign rd_addr = {k, lut_index};

    assign conn_bad = cfg_sel && ((int'(cfg_addr[FW-1:0]) >= FANIN) ||
                                  (int'(cfg_wdata[CW-1:0]) >= IN_CH));
    assign cfg_take = cfg_we && cfg_ready && !conn_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            vec      <= '0;
            k        <= '0;
            rd_valid <= 1'b0;
            rd_k     <= '0;
            out_data <= '0;
            cfg_err  <= 1'b0;
            for (int i = 0; i < NEURONS*FANIN; i++) begin
                conn[AW'(i)] <= CW'(i % IN_CH);
            end
        end else begin
            state <= state_next;
            if (accept) begin
                vec <= in_data;
                k   <= '0;
            end else if (issue) begin
                k <= k + 1'b1;
            end
            rd_valid <= issue;
            rd_k     <= k;
            if (rd_valid) out_data[int'(rd_k)*OUT_BW +: OUT_BW] <= rd_data;
            cfg_err <= cfg_we && (!cfg_ready || conn_bad);
            if (cfg_take && cfg_sel) conn[cfg_addr[AW-1:0]] <= cfg_wdata[CW-1:0];
        end
    end

    // Truth-table RAM has no reset; writes only land in IDLE, so reads never collide.
    always_ff @(posedge clk) begin
        if (cfg_take && !cfg_sel) ram[cfg_addr] <= cfg_wdata[OUT_BW-1:0];
        rd_data <= ram[rd_addr];
    end

endmodule
